// File: rtl/fir_job_sched.sv
// fir_job_sched -- descriptor-driven job scheduler for fir_core's control slave.
//
// Software stages a descriptor (X/H/Y base addresses) in three registers and
// pushes it into a small FIFO. When enabled, the scheduler pops jobs in order:
// it programs fir_core (a0..a2), pulses start (a3=1 then a3=0), polls the
// core's status register until done, then retires the job. A job that runs
// longer than TIMEOUT_CYC cycles from the start write is aborted and dropped.
//
// Optional build macro: FIR_SCHED_IRQ_EN (completion/abort interrupt).
//
// Ports
//   iClk, iRst                 clock, asynchronous active-high reset
//   iChipSelect/iWrite/iRead   host slave strobes, iAddress register index,
//   iData/oData                write data / registered read data (1 cycle)
//   o*_Fir / iData_Fir         master port onto fir_core's control slave
//   oIrq                       interrupt (0 unless FIR_SCHED_IRQ_EN)
//
// Register map: 0 DESC_X, 1 DESC_H, 2 DESC_Y, 3 PUSH, 4 STATUS,
//   5 DONE_COUNT, 6 CTRL {clr_sticky, irq_en, flush, enable}, 7 IRQ.
module fir_job_sched #(
  parameter int         DEPTH       = 4,
  parameter logic [4:0] STATUS_ADDR = 5'h04,
  parameter int         POLL_GAP    = 2,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iChipSelect,
  input  logic        iWrite,
  input  logic        iRead,
  input  logic [2:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oChipSelect_Fir,
  output logic        oWrite_Fir,
  output logic        oRead_Fir,
  output logic [4:0]  oAddress_Fir,
  output logic [31:0] oData_Fir,
  input  logic [31:0] iData_Fir,
  output logic        oIrq
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = 4;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] h;
    logic [31:0] y;
  } desc_t;

  typedef enum logic [3:0] {
    IDLE, WR_X, WR_H, WR_Y, WR_GO, WR_STOP, SETTLE, POLL_RD, POLL_CHK, GAP, POP
  } state_t;

  state_t               state, stateNxt;
  desc_t                stage, head;
  desc_t [DEPTH-1:0]    fifoMem;
  logic [AW-1:0]        wrPtr, rdPtr, rdNext;
  logic [AW:0]          count;
  logic                 ovf, tmo, enable, irqEn, irqPend;
  logic [31:0]          doneCount, status, rdMux;
  logic [TW-1:0]        tmr;
  logic [GW-1:0]        gapCnt;
  logic                 slvWr, slvRd, pushReq, flushReq, clrReq, pushOk;
  logic                 fullNow, emptyNow, busy, inJob, timedOut, keepHead;
  logic                 popNow, abortNow, fireDone;
  logic                 unusedFirBits;

  // Only the done flag of fir_core's status word matters here.
  assign unusedFirBits = ^iData_Fir[31:1];
  assign fireDone      = iData_Fir[0];

  assign slvWr    = iChipSelect & iWrite;
  assign slvRd    = iChipSelect & iRead;
  assign pushReq  = slvWr && iAddress == 3'd3;
  assign flushReq = slvWr && iAddress == 3'd6 && iData[1];
  assign clrReq   = slvWr && iAddress == 3'd6 && iData[3];
  assign fullNow  = count == (AW+1)'(DEPTH);
  assign emptyNow = count == '0;
  assign busy     = state != IDLE;
  assign head     = fifoMem[rdPtr];
  // States after the start write, where the timeout is live.
  assign inJob    = state inside {WR_STOP, SETTLE, POLL_RD, POLL_CHK, GAP};
  assign timedOut = tmr == TW'(TIMEOUT_CYC - 1);
  // A pop in the same cycle frees the slot, so a push while full is accepted.
  assign pushOk   = pushReq && !flushReq && (!fullNow || popNow);
  assign rdNext   = popNow ? rdPtr + 1'b1 : rdPtr;
  // Flush keeps the in-flight head so the running job still sees its descriptor.
  assign keepHead = busy && !popNow;

  always_comb begin
    stateNxt        = state;
    oChipSelect_Fir = 1'b0;
    oWrite_Fir      = 1'b0;
    oRead_Fir       = 1'b0;
    oAddress_Fir    = '0;
    oData_Fir       = '0;
    popNow          = 1'b0;
    abortNow        = 1'b0;
    case (state)
      IDLE:     if (enable && !emptyNow && !flushReq) stateNxt = WR_X;
      WR_X:     begin oChipSelect_Fir = 1'b1; oWrite_Fir = 1'b1; oAddress_Fir = 5'd0;
                      oData_Fir = head.x; stateNxt = WR_H; end
      WR_H:     begin oChipSelect_Fir = 1'b1; oWrite_Fir = 1'b1; oAddress_Fir = 5'd1;
                      oData_Fir = head.h; stateNxt = WR_Y; end
      WR_Y:     begin oChipSelect_Fir = 1'b1; oWrite_Fir = 1'b1; oAddress_Fir = 5'd2;
                      oData_Fir = head.y; stateNxt = WR_GO; end
      WR_GO:    begin oChipSelect_Fir = 1'b1; oWrite_Fir = 1'b1; oAddress_Fir = 5'd3;
                      oData_Fir = 32'd1; stateNxt = WR_STOP; end
      WR_STOP:  begin oChipSelect_Fir = 1'b1; oWrite_Fir = 1'b1; oAddress_Fir = 5'd3;
                      stateNxt = SETTLE; end
      // One dead cycle so the first poll cannot see the previous job's done.
      SETTLE:   stateNxt = POLL_RD;
      POLL_RD:  begin oChipSelect_Fir = 1'b1; oRead_Fir = 1'b1; oAddress_Fir = STATUS_ADDR;
                      stateNxt = POLL_CHK; end
      POLL_CHK: if (fireDone)          stateNxt = POP;
                else if (POLL_GAP == 0) stateNxt = POLL_RD;
                else                    stateNxt = GAP;
      GAP:      if (gapCnt == GW'(POLL_GAP - 1)) stateNxt = POLL_RD;
      POP:      begin popNow = 1'b1; stateNxt = IDLE; end
      default:  stateNxt = IDLE;
    endcase
    // A done seen on the last allowed cycle still counts as a completion.
    if (inJob && timedOut && !(state == POLL_CHK && fireDone)) begin
      stateNxt = IDLE;
      abortNow = 1'b1;
      popNow   = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst)
    if (iRst) state <= IDLE;
    else      state <= stateNxt;

  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      tmr    <= '0;
      gapCnt <= '0;
    end else begin
      if (state == WR_GO) tmr <= TW'(1);
      else if (inJob)     tmr <= tmr + 1'b1;
      if (state == GAP)   gapCnt <= gapCnt + 1'b1;
      else                gapCnt <= '0;
    end

  // Descriptor storage needs no reset; it is only read after a push.
  always_ff @(posedge iClk)
    if (pushOk) fifoMem[wrPtr] <= stage;

  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flushReq) begin
      rdPtr <= rdNext;
      wrPtr <= rdNext + AW'(keepHead);
      count <= (AW+1)'(keepHead);
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      rdPtr <= rdNext;
      count <= count + (AW+1)'(pushOk) - (AW+1)'(popNow);
    end

  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      stage     <= '0;
      enable    <= 1'b0;
      ovf       <= 1'b0;
      tmo       <= 1'b0;
      doneCount <= '0;
    end else begin
      if (slvWr && iAddress == 3'd0) stage.x <= iData;
      if (slvWr && iAddress == 3'd1) stage.h <= iData;
      if (slvWr && iAddress == 3'd2) stage.y <= iData;
      if (slvWr && iAddress == 3'd6) enable  <= iData[0];
      // A new event wins over a same-cycle sticky clear.
      if (pushReq && !flushReq && fullNow && !popNow) ovf <= 1'b1;
      else if (clrReq)                                 ovf <= 1'b0;
      if (abortNow)    tmo <= 1'b1;
      else if (clrReq) tmo <= 1'b0;
      if (slvWr && iAddress == 3'd5) doneCount <= '0;
      else if (state == POP)         doneCount <= doneCount + 1'b1;
    end

`ifdef FIR_SCHED_IRQ_EN
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      irqEn   <= 1'b0;
      irqPend <= 1'b0;
    end else begin
      if (slvWr && iAddress == 3'd6) irqEn <= iData[2];
      if ((state == POP || abortNow) && irqEn)         irqPend <= 1'b1;
      else if (slvWr && iAddress == 3'd7 && iData[0])  irqPend <= 1'b0;
    end
`else
  assign irqEn   = 1'b0;
  assign irqPend = 1'b0;
`endif
  assign oIrq = irqPend;

  always_comb begin
    status            = '0;
    status[0]         = busy;
    status[1]         = emptyNow;
    status[2]         = fullNow;
    status[3]         = ovf;
    status[4]         = tmo;
    status[8 +: AW+1] = count;
  end

  always_comb begin
    rdMux = '0;
    case (iAddress)
      3'd0: rdMux = stage.x;
      3'd1: rdMux = stage.h;
      3'd2: rdMux = stage.y;
      3'd4: rdMux = status;
      3'd5: rdMux = doneCount;
      3'd6: rdMux = {29'd0, irqEn, 1'b0, enable};
      3'd7: rdMux = {31'd0, irqPend};
      default: rdMux = '0;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst)
    if (iRst)       oData <= '0;
    else if (slvRd) oData <= rdMux;
endmodule

// File: tb/tb_fir_job_sched.sv
`timescale 1ns/1ps
module tb_fir_job_sched;
  localparam int T = 4096;

  logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0, rdata, firRdata = '0, firWdata;
  logic        firCs, firWr, firRd, irq;
  logic [4:0]  firAddr;

  int errors = 0, checks = 0;
  int cyc = 0;

  // bench-side fir_core model state
  logic [36:0] expQ[$];
  int  finLat = 40, remain = -1, goCyc = -1, doneRdCyc = -1, lastWrCyc = 0, firstXCyc = -1;
  bit  done = 1'b0;

  fir_job_sched dut (
    .iClk(clk), .iRst(rst), .iChipSelect(cs), .iWrite(wr), .iRead(rd),
    .iAddress(addr), .iData(wdata), .oData(rdata),
    .oChipSelect_Fir(firCs), .oWrite_Fir(firWr), .oRead_Fir(firRd),
    .oAddress_Fir(firAddr), .oData_Fir(firWdata), .iData_Fir(firRdata), .oIrq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // fir_core stand-in plus write scoreboard, evaluated mid-cycle.
  task automatic firModel();
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done = 1'b0; remain = -1;
      end else begin
        if (remain > 0) begin
          remain--;
          if (remain == 0) done = 1'b1;
        end
        if (firCs && firRd) begin
          firRdata = {31'd0, done};
          if (done && doneRdCyc < 0) doneRdCyc = cyc;
        end
        if (firCs && firWr) begin
          chk("wr_pending", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("wr_addr", {27'd0, firAddr}, {27'd0, e[36:32]});
            chk("wr_data", firWdata, e[31:0]);
          end
          if (firAddr != 5'd0) chk("wr_consec", cyc, lastWrCyc + 1);
          else firstXCyc = cyc;
          lastWrCyc = cyc;
          if (firAddr == 5'd3 && firWdata == 32'd1) begin
            goCyc = cyc; done = 1'b0; remain = finLat;
          end
        end
      end
    end
  endtask

  task automatic wrReg(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rdReg(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    d = rdata; cs = 1'b0; rd = 1'b0;
  endtask

  task automatic pushJob(input logic [31:0] x, input logic [31:0] h, input logic [31:0] y, input bit willRun);
    wrReg(3'd0, x); wrReg(3'd1, h); wrReg(3'd2, y); wrReg(3'd3, 32'd0);
    if (willRun) begin
      expQ.push_back({5'd0, x}); expQ.push_back({5'd1, h}); expQ.push_back({5'd2, y});
      expQ.push_back({5'd3, 32'd1}); expQ.push_back({5'd3, 32'd0});
    end
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin rdReg(3'd4, s); n++; end while (!(s[0] == 1'b0 && s[1] == 1'b1) && n < 12000);
    chk({tag, "_idle"}, {30'd0, s[1:0]}, 32'h2);
  endtask

  task automatic waitGo(input string tag);
    int n = 0;
    while (goCyc < 0 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_go_seen"}, goCyc >= 0, 1);
  endtask

  initial begin
    logic [31:0] s;
    int n, ctrlCyc;
    fork
      firModel();
      begin #5ms; $display("FAIL watchdog: observed=timeout expected=finish"); $fatal(1); end
    join_none

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_odata", rdata, 0);
    chk("rst_fir_strobes", {29'd0, firCs, firWr, firRd}, 0);
    chk("rst_fir_addr", {27'd0, firAddr}, 0);
    chk("rst_fir_data", firWdata, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    @(negedge clk);
    rdReg(3'd4, s); chk("rst_status", s, 32'h2);
    rdReg(3'd5, s); chk("rst_donecnt", s, 0);
    rdReg(3'd6, s); chk("rst_ctrl", s, 0);

    // single job
    pushJob(32'd0, 32'd8, 32'd16, 1);
    ctrlCyc = cyc;
    wrReg(3'd6, 32'h1);
    waitIdle("job1");
    chk("job1_launch_lat", firstXCyc, ctrlCyc + 2);
    rdReg(3'd5, s); chk("job1_donecnt", s, 1);
    rdReg(3'd4, s); chk("job1_status", s, 32'h2);
    rdReg(3'd2, s); chk("job1_desc_y", s, 16);

    // fill the queue, overflow, then run in order
    wrReg(3'd6, 32'h0); wrReg(3'd5, 32'h0);
    for (int i = 0; i < 4; i++) pushJob(32'h100 + i, 32'h200 + i, 32'h300 + i, 1);
    pushJob(32'hDEAD, 32'hBEEF, 32'hCAFE, 0);
    rdReg(3'd4, s); chk("full_status", s, 32'h40C);
    wrReg(3'd6, 32'h1);
    waitIdle("q4");
    rdReg(3'd5, s); chk("q4_donecnt", s, 4);
    rdReg(3'd4, s); chk("q4_status_ovf", s, 32'hA);
    wrReg(3'd6, 32'h9);
    rdReg(3'd4, s); chk("clr_sticky", s, 32'h2);
    rdReg(3'd6, s); chk("ctrl_selfclr", s, 1);

    // push on the exact POP cycle while full
    wrReg(3'd6, 32'h0); wrReg(3'd5, 32'h0);
    for (int i = 0; i < 4; i++) pushJob(32'h400 + i, 32'h410 + i, 32'h420 + i, 1);
    wrReg(3'd0, 32'h500); wrReg(3'd1, 32'h510); wrReg(3'd2, 32'h520);
    doneRdCyc = -1;
    wrReg(3'd6, 32'h1);
    n = 0;
    while (!(doneRdCyc >= 0 && cyc == doneRdCyc + 2) && n < 500) begin @(negedge clk); n++; end
    chk("popfull_sync", n < 500, 1);
    wrReg(3'd3, 32'h0);
    expQ.push_back({5'd0, 32'h500}); expQ.push_back({5'd1, 32'h510}); expQ.push_back({5'd2, 32'h520});
    expQ.push_back({5'd3, 32'd1}); expQ.push_back({5'd3, 32'd0});
    rdReg(3'd4, s);
    chk("popfull_ovf", s[3], 0);
    chk("popfull_count", {27'd0, s[12:8]}, 4);
    waitIdle("popfull");
    rdReg(3'd5, s); chk("popfull_donecnt", s, 5);

    // timeout on a job that never finishes, next job still runs
    wrReg(3'd6, 32'h0); wrReg(3'd5, 32'h0);
    pushJob(32'h600, 32'h610, 32'h620, 1);
    pushJob(32'h700, 32'h710, 32'h720, 1);
    finLat = -1; goCyc = -1;
    wrReg(3'd6, 32'h1);
    waitGo("tmo");
    while (goCyc >= 0 && cyc < goCyc + T - 1) @(negedge clk);
    rdReg(3'd4, s); chk("tmo_before", s[4], 0);
    rdReg(3'd4, s); chk("tmo_at", s[4], 1);
    finLat = 40;
    waitIdle("tmo");
    rdReg(3'd5, s); chk("tmo_donecnt", s, 1);
    rdReg(3'd4, s); chk("tmo_status", s, 32'h12);
    wrReg(3'd6, 32'h9);
    rdReg(3'd4, s); chk("tmo_clr", s, 32'h2);

    // flush with one running and three queued
    wrReg(3'd6, 32'h0); wrReg(3'd5, 32'h0);
    pushJob(32'h800, 32'h810, 32'h820, 1);
    for (int i = 1; i < 4; i++) pushJob(32'h800 + i, 32'h810 + i, 32'h820 + i, 0);
    goCyc = -1;
    wrReg(3'd6, 32'h1);
    waitGo("flush");
    wrReg(3'd6, 32'h3);
    rdReg(3'd4, s);
    chk("flush_count", {27'd0, s[12:8]}, 1);
    chk("flush_busy", s[0], 1);
    waitIdle("flush");
    rdReg(3'd5, s); chk("flush_donecnt", s, 1);
    rdReg(3'd4, s); chk("flush_status", s, 32'h2);

    // asynchronous reset during polling
    pushJob(32'h900, 32'h910, 32'h920, 1);
    n = 0;
    while (!firRd && n < 200) begin @(negedge clk); n++; end
    chk("arst_poll_seen", firRd, 1);
    rst = 1'b1;
    #1;
    chk("arst_fir_strobes", {29'd0, firCs, firWr, firRd}, 0);
    chk("arst_fir_addr", {27'd0, firAddr}, 0);
    chk("arst_odata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rdReg(3'd4, s); chk("arst_status", s, 32'h2);
    rdReg(3'd5, s); chk("arst_donecnt", s, 0);
    rdReg(3'd6, s); chk("arst_ctrl", s, 0);

    // interrupt
    wrReg(3'd6, 32'h5);
    pushJob(32'hA00, 32'hA10, 32'hA20, 1);
    waitIdle("irq");
`ifdef FIR_SCHED_IRQ_EN
    chk("irq_set", irq, 1);
    rdReg(3'd7, s); chk("irq_reg", s, 1);
    wrReg(3'd7, 32'h1);
    chk("irq_clr", irq, 0);
    rdReg(3'd6, s); chk("irq_ctrl", s, 5);
`else
    chk("irq_off", irq, 0);
    rdReg(3'd7, s); chk("irq_reg_off", s, 0);
    rdReg(3'd6, s); chk("irq_ctrl_off", s, 1);
`endif
    rdReg(3'd5, s); chk("irq_donecnt", s, 1);

    chk("sb_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
